// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 8-master shared system bus. It adds a one-cycle turnaround between owners
// and a hold-time watchdog. o_grant drives the one-hot select of the bus data mux.
module bus_arbiter #(
  parameter int N_MASTERS = 8,
  parameter int TIMEOUT   = 256,
  parameter int CNT_W     = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_MASTERS-1:0]         i_req,
  output logic [N_MASTERS-1:0]         o_grant,
  output logic [$clog2(N_MASTERS)-1:0] o_grant_id,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int              ID_W     = $clog2(N_MASTERS);
  localparam logic            WDOG_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [ID_W-1:0]  ID_ZERO  = {ID_W{1'b0}};
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] GRANT_ZERO = {N_MASTERS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               r_state;
  logic [N_MASTERS-1:0] r_grant;
  logic [ID_W-1:0]      r_grant_id;
  logic                 r_busy;
  logic                 r_timeout;
  logic [CNT_W-1:0]     r_cnt;
  logic [ID_W-1:0]      r_last;

  state_t               w_state_nxt;
  logic [N_MASTERS-1:0] w_grant_nxt;
  logic [ID_W-1:0]      w_grant_id_nxt;
  logic                 w_busy_nxt;
  logic                 w_timeout_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [ID_W-1:0]      w_last_nxt;

  logic                 w_found;
  logic [ID_W-1:0]      w_winner;
  logic [ID_W-1:0]      w_idx;
  logic                 w_owner_req;

  // Binary index to one-hot mux select; the result can never have more than one bit set.
  function automatic logic [N_MASTERS-1:0] f_decode(input logic [ID_W-1:0] idx);
    logic [N_MASTERS-1:0] v_sel;
    v_sel = GRANT_ZERO;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (idx == ID_W'(i)) begin
        v_sel[i] = 1'b1;
      end else begin
        v_sel[i] = 1'b0;
      end
    end
    return v_sel;
  endfunction

  // Rotating search: first requester after the previous winner, wrapping modulo N_MASTERS.
  always_comb begin
    w_found  = 1'b0;
    w_winner = ID_ZERO;
    w_idx    = ID_ZERO;
    for (int k = 1; k <= N_MASTERS; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % N_MASTERS);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

  assign w_owner_req = i_req[r_grant_id];

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_timeout_nxt  = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_last_nxt     = r_last;
    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (w_found) begin
          w_state_nxt    = ST_GRANT;
          w_grant_nxt    = f_decode(w_winner);
          w_grant_id_nxt = w_winner;
          w_last_nxt     = w_winner;
          w_cnt_nxt      = CNT_ZERO;
        end else begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = GRANT_ZERO;
          w_grant_id_nxt = ID_ZERO;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req) begin
          w_state_nxt    = ST_RELEASE;
          w_grant_nxt    = GRANT_ZERO;
          w_grant_id_nxt = ID_ZERO;
        end else if (WDOG_EN && (r_cnt == CNT_LAST)) begin
          // r_last already names the revoked owner, so it ranks last next round.
          w_state_nxt    = ST_RELEASE;
          w_grant_nxt    = GRANT_ZERO;
          w_grant_id_nxt = ID_ZERO;
          w_timeout_nxt  = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt      = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt      = r_cnt;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_grant_nxt    = GRANT_ZERO;
        w_grant_id_nxt = ID_ZERO;
        w_cnt_nxt      = CNT_ZERO;
        w_last_nxt     = ID_LAST;
      end
    endcase
    w_busy_nxt = |w_grant_nxt;
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= GRANT_ZERO;
      r_grant_id <= ID_ZERO;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt      <= CNT_ZERO;
      r_last     <= ID_LAST;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_grant_id = r_grant_id;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomised bench for bus_arbiter: a cycle-level ownership model
// plus literal expectations for reset, rotation, wrap and watchdog cases.
module tb_bus_arbiter;

  localparam int TB_TO = 6;

  logic       clk;
  logic       rst;
  logic [7:0] req;

  logic [7:0] o_grant;
  logic [2:0] o_grant_id;
  logic       o_busy;
  logic       o_timeout;

  logic [7:0] wd_grant;
  logic [2:0] wd_grant_id;
  logic       wd_busy;
  logic       wd_timeout;

  int n_pass  = 0;
  int n_total = 0;

  bus_arbiter #(.N_MASTERS(8), .TIMEOUT(TB_TO), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .o_grant(o_grant), .o_grant_id(o_grant_id), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  bus_arbiter #(.N_MASTERS(8), .TIMEOUT(4), .CNT_W(16)) u_wd (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .o_grant(wd_grant), .o_grant_id(wd_grant_id), .o_busy(wd_busy), .o_timeout(wd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Ownership model: owner index (-1 = bus free), cycles held so far, last winner.
  int m_owner = -1;
  int m_hold  = 0;
  int m_last  = 7;
  bit m_to    = 1'b0;
  bit m_valid = 1'b0;

  function automatic int rr_pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_grant(input int owner);
    return (owner < 0) ? 8'h00 : 8'(1 << owner);
  endfunction

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_owner <= -1; m_hold <= 0; m_last <= 7; m_to <= 1'b0;
    end else if (m_owner < 0) begin
      m_to <= 1'b0;
      if (req != 8'h00) begin
        m_owner <= rr_pick(req, m_last);
        m_last  <= rr_pick(req, m_last);
        m_hold  <= 1;
      end
    end else if (!req[m_owner]) begin
      m_owner <= -1; m_to <= 1'b0;
    end else if (m_hold == TB_TO) begin
      m_owner <= -1; m_to <= 1'b1;
    end else begin
      m_hold <= m_hold + 1; m_to <= 1'b0;
    end
  end

  logic [7:0] prev_grant = 8'h00;

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_grant",   32'(o_grant),    32'(exp_grant(m_owner)));
      check("model_id",      32'(o_grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      check("model_busy",    32'(o_busy),     32'(m_owner >= 0));
      check("model_timeout", 32'(o_timeout),  32'(m_to));
      check("onehot",        32'((o_grant & (o_grant - 8'd1)) == 8'h00), 32'd1);
      check("id_match",      32'((o_grant == 8'h00) ? (o_grant_id == 3'd0)
                                                     : (o_grant == (8'h01 << o_grant_id))), 32'd1);
      check("turnaround",    32'(!((prev_grant != 8'h00) && (o_grant != 8'h00) && (prev_grant != o_grant))), 32'd1);
      prev_grant <= o_grant;
    end
  end

  logic [7:0] exp6 [0:7] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08};
  logic       to6  [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp4 [0:5] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08};
  logic       to4  [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [7:0] rr_exp;
    rst = 1'b1; req = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_id",    32'(o_grant_id), 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);
    check("rst_to",    32'(o_timeout), 32'h0);
    rst = 1'b0;

    // single master: five cycles of ownership, one RELEASE, then IDLE
    req = 8'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("single_grant", 32'(o_grant), 32'h10);
      check("single_id",    32'(o_grant_id), 32'd4);
      check("single_busy",  32'(o_busy), 32'd1);
    end
    req = 8'h00;
    @(negedge clk); check("single_release", 32'(o_grant), 32'h0);
    @(negedge clk); check("single_idle",    32'(o_grant), 32'h0);

    // last=4, all requesting -> master 5; then reset mid-grant
    req = 8'hFF;
    @(negedge clk); check("after4_grant", 32'(o_grant), 32'h20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_grant", 32'(o_grant), 32'h0);
    check("midrst_id",    32'(o_grant_id), 32'h0);
    check("midrst_busy",  32'(o_busy), 32'h0);
    check("midrst_to",    32'(o_timeout), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // round robin 01,02,...,80,01 with a dead cycle between owners
    for (int j = 0; j < 9; j++) begin
      rr_exp = 8'h01 << (j % 8);
      check("rr_first", 32'(o_grant), 32'(rr_exp));
      if (j < 8) begin
        @(negedge clk); check("rr_second", 32'(o_grant), 32'(rr_exp));
        req = 8'hFF & ~rr_exp;
        @(negedge clk); check("rr_gap", 32'(o_grant), 32'h0);
        req = 8'hFF;
        @(negedge clk);
      end
    end
    req = 8'h00;
    repeat (2) @(negedge clk);

    // wrap and skip: last=6, req=05 -> 01 then 04
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 8'h40;
    @(negedge clk); check("wrap_setup", 32'(o_grant), 32'h40);
    req = 8'h00;
    @(negedge clk); check("wrap_gap0", 32'(o_grant), 32'h0);
    req = 8'h05;
    @(negedge clk); check("wrap_first", 32'(o_grant), 32'h01);
    req = 8'h04;
    @(negedge clk); check("wrap_gap1", 32'(o_grant), 32'h0);
    @(negedge clk); check("wrap_second", 32'(o_grant), 32'h04);
    check("wrap_id", 32'(o_grant_id), 32'd2);
    req = 8'h00;
    repeat (2) @(negedge clk);

    // watchdog on both instances (TIMEOUT 6 and 4)
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 8'h08;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("wd6_grant", 32'(o_grant), 32'(exp6[c]));
      check("wd6_to",    32'(o_timeout), 32'(to6[c]));
      if (c < 6) begin
        check("wd4_grant", 32'(wd_grant), 32'(exp4[c]));
        check("wd4_to",    32'(wd_timeout), 32'(to4[c]));
      end
    end
    req = 8'h00;
    repeat (2) @(negedge clk);

    // random traffic with occasional reset; the model process checks every cycle
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; req = 8'h00;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the 8-master shared system bus. Samples per-master request lines, grants the bus to exactly one master at a time, and drives the one-hot `grant` vector straight into the 8-way one-hot bus data mux select. A watchdog forcibly reclaims the bus from a master that holds it too long. A one-cycle turnaround (no grant) is inserted between owners, so the mux outputs 0 between transfers.

## Interface
- `N_MASTERS`, 8: number of masters; fixed at 8 to match the 8-way mux select width.
- `TIMEOUT`, 256: maximum consecutive cycles one master may hold a grant; 0 disables the watchdog.
- `CNT_W`, 16: hold-counter width; must satisfy 2^CNT_W > TIMEOUT.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  8  per-master bus request; bit i = master i; held high for the whole transfer.
- `grant`  out  8  one-hot grant, registered; all-zero when no owner; connects to mux `sel`.
- `grant_id`  out  3  binary index of current owner; 0 when `grant` is 0.
- `busy`  out  1  high while any grant is asserted (equals |grant).
- `timeout`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, GRANT, RELEASE. All outputs registered.
- Reset (`rst`=1 at an edge): state=IDLE, `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0, hold counter=0, round-robin pointer `last`=7 (master 0 highest priority first). Reset during GRANT drops the grant at that edge; no RELEASE cycle.
- Arbitration (IDLE or RELEASE, `req`≠0): winner = first set bit of `req` searching `last+1, last+2, …` modulo 8. Next edge: state=GRANT, `grant`=1<<winner, `grant_id`=winner, `last`=winner, counter=0.
- IDLE with `req`=0: stay IDLE.
- GRANT: bus held while `req[grant_id]`=1. Requests from other masters are ignored (no preemption). Counter increments each GRANT cycle, saturating at its maximum.
- Normal release: `req[grant_id]`=0 sampled in GRANT → next edge state=RELEASE, `grant`=0, `grant_id`=0.
- Watchdog (`TIMEOUT`>0): when counter = TIMEOUT-1 and `req[grant_id]` still 1 → next edge state=RELEASE, `grant`=0, `timeout`=1 for that one cycle only. The revoked master keeps no privilege; `last` already points at it, so it has lowest priority in the next arbitration.
- RELEASE: exactly one cycle with `grant`=0. Arbitration runs in this cycle. Next edge goes to GRANT if `req`≠0, otherwise to IDLE.
- Invariant: `grant` is always zero or exactly one-hot. Never two bits set, never a non-one-hot value.

## Timing
- Request-to-grant latency from IDLE: `req` high before edge k → `grant` valid after edge k (1 cycle).
- Release-to-next-grant: owner drops `req` before edge k → `grant`=0 after k (RELEASE) → new grant after k+1. Minimum 1 dead cycle between owners.
- Maximum hold: a continuously requesting master holds `grant` for exactly TIMEOUT cycles.
- Owner request low on its first GRANT cycle: grant lasts exactly 1 cycle, then RELEASE.
- Owner re-raising `req` in the RELEASE cycle: competes normally; it loses to any other requester because of pointer rotation.
- `busy` and `grant_id` change on the same edge as `grant`.

## Test plan
- Reset: assert `rst` mid-GRANT with `req`=8'hFF → after next edge `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0. After release of `rst` with `req`=8'hFF → `grant`=8'h01.
- Single master: `req`=8'h10 for 5 cycles, then 0 → `grant`=8'h10, `grant_id`=4 for 5 cycles starting 1 cycle after `req` rises; then one RELEASE cycle with `grant`=0; then IDLE.
- Round-robin: `req`=8'hFF held, each owner drops its bit for one cycle after 2 cycles of ownership → grant sequence 01,02,04,…,80,01, with one zero cycle between each pair of owners.
- Wrap and skip: `last`=6, `req`=8'h05 → `grant`=8'h01, then 8'h04 after master 0 releases.
- Watchdog: TIMEOUT=4, `req`=8'h08 held → `grant`=8'h08 for exactly 4 cycles, `timeout` pulses for 1 cycle together with `grant`=0, then `grant`=8'h08 again on the following cycle if it is still the only requester.
- One-hot invariant: random `req` for 10k cycles → `grant` always zero or one-hot, `grant_id` matches `grant`, and no owner change occurs without an intervening zero cycle.
